limit_fsm_cond: RTL and testbench
=================================

LIMIT_FSM_COND -- requirements
Module: limit_fsm_cond

Interface
REQ-001 SHALL have parameter CNT_W, default 4, meaning occupancy counter width.
REQ-002 SHALL have parameter CNT_MAX, default 15, meaning highest legal occupancy, not exceeding 2**CNT_W-1.
REQ-003 SHALL have port clk  input  1  single system clock, all state updates on its rising edge.
REQ-004 SHALL have port reset_L  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port push  input  1  one-cycle occupancy increment request.
REQ-006 SHALL have port pop  input  1  one-cycle occupancy decrement request.
REQ-007 SHALL have port top_thr  input  CNT_W  upper threshold, sampled only in INIT.
REQ-008 SHALL have port bott_thr  input  CNT_W  lower threshold, sampled only in INIT.
REQ-009 SHALL have port top_lim  output  1  registered, high while state is TOP; feeds top_lim_cond of the downstream checker.
REQ-010 SHALL have port bott_lim  output  1  registered, high while state is BOTTOM; feeds bott_lim_cond of the downstream checker.
REQ-011 SHALL have port err  output  1  registered, high while state is ERROR.
REQ-012 SHALL have port count  output  CNT_W  current registered occupancy.

Function
REQ-013 SHALL implement states INIT, BOTTOM, MID, TOP, ERROR.
REQ-014 SHALL, in INIT, ignore push/pop and latch top_thr/bott_thr into top_q/bott_q on the first rising edge after reset release.
REQ-015 SHALL go INIT->ERROR on that edge if bott_thr >= top_thr or top_thr > CNT_MAX; otherwise INIT->BOTTOM.
REQ-016 SHALL, outside INIT/ERROR, compute count_next: push only and count<CNT_MAX -> +1; pop only and count>0 -> -1; push and pop together -> unchanged; neither -> unchanged.
REQ-017 SHALL treat push only at count==CNT_MAX (overflow) or pop only at count==0 (underflow) as error: count holds, next state ERROR.
REQ-018 SHALL select next state from count_next: count_next <= bott_q -> BOTTOM; count_next >= top_q -> TOP; else MID.
REQ-019 SHALL update count and state on the same edge, so top_lim/bott_lim change exactly one cycle after the push/pop that crosses a threshold is sampled.
REQ-020 SHALL never assert top_lim and bott_lim together.
REQ-021 SHALL keep ERROR sticky until reset_L falls; in ERROR top_lim=0, bott_lim=0, err=1, count frozen.
REQ-022 SHALL hold top_lim, bott_lim and err low in INIT.

Reset
REQ-023 SHALL, while reset_L=0, force state=INIT, count=0, top_q=0, bott_q=0, top_lim=0, bott_lim=0, err=0 immediately, independent of clk.
REQ-024 SHALL abandon any operation when reset_L falls mid-run; after release, rebehave exactly as from power-up (INIT, re-sample thresholds).

Structure
REQ-025 SHALL take state encodings (INIT=3'd0, BOTTOM=3'd1, MID=3'd2, TOP=3'd3, ERROR=3'd4) from the shared definitions.v macros, also used by the structural and delay variants.
REQ-026 SHALL place the saturating occupancy counter (push/pop/overflow/underflow flags) in one sub-module lim_counter; FSM and output registers stay in limit_fsm_cond.
REQ-027 SHALL keep all outputs registered, so the structural and delay variants are cycle-comparable with this model.

Verification
REQ-028 SHALL cover: reset release with top_thr=12, bott_thr=3 -> cycle 1 INIT, cycle 2 BOTTOM, bott_lim=1, count=0.
REQ-029 SHALL cover: 4 pushes from 0 (thr 12/3) -> bott_lim falls the cycle after count becomes 4; 8 more pushes -> top_lim rises the cycle after count becomes 12.
REQ-030 SHALL cover: push and pop together at count=12 -> count stays 12, top_lim stays 1; then one pop -> count 11, top_lim=0 next cycle.
REQ-031 SHALL cover: push at count=15 -> err=1, top_lim=0, count=15 held; further pops ignored until reset.
REQ-032 SHALL cover: top_thr=5, bott_thr=5 at reset release -> ERROR, err=1 after first edge.
REQ-033 SHALL cover: reset_L pulled low mid-count at count=7 -> all outputs 0 and count=0 without waiting for a clk edge.

Source files
------------

// File: rtl/limit_fsm_cond_pkg.sv
// rtl/limit_fsm_cond_pkg.sv - shared state encodings and output-flag decode for the occupancy limit FSM
package limit_fsm_cond_pkg;

  // Encodings are fixed so the structural and delay variants stay cycle-comparable.
  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_BOTTOM = 3'd1,
    ST_MID    = 3'd2,
    ST_TOP    = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  typedef struct packed {
    logic top;
    logic bott;
    logic err;
  } lim_flags_t;

  // Output flags are a pure function of the state being entered.
  function automatic lim_flags_t flags_for(state_e s);
    lim_flags_t f;
    f = '0;
    case (s)
      ST_TOP:    f.top  = 1'b1;
      ST_BOTTOM: f.bott = 1'b1;
      ST_ERROR:  f.err  = 1'b1;
      default:   f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/limit_fsm_cond_counter.sv
// rtl/limit_fsm_cond_counter.sv - saturating occupancy counter with overflow/underflow detection
module lim_counter #(
  parameter int CNT_W   = 4,
  parameter int CNT_MAX = 15
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             en,
  input  logic             push,
  input  logic             pop,
  output logic [CNT_W-1:0] count_q,
  output logic [CNT_W-1:0] count_next,
  output logic             ovf,
  output logic             unf
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(CNT_MAX);

  logic [CNT_W-1:0] count_d;

  // Next occupancy: single push/pop moves by one; a blocked move flags ovf/unf and holds.
  always_comb begin
    ovf        = 1'b0;
    unf        = 1'b0;
    count_next = count_q;
    if (en && push && !pop) begin
      if (count_q == MAX_V) begin
        ovf = 1'b1;
      end else begin
        count_next = count_q + CNT_W'(1);
      end
    end else if (en && pop && !push) begin
      if (count_q == '0) begin
        unf = 1'b1;
      end else begin
        count_next = count_q - CNT_W'(1);
      end
    end
    count_d = count_next;
  end

  // Occupancy register; frozen whenever the FSM disables counting.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/limit_fsm_cond.sv
// rtl/limit_fsm_cond.sv - occupancy limit FSM producing registered top/bottom/error conditions
module limit_fsm_cond
  import limit_fsm_cond_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int CNT_MAX = 15
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             push,
  input  logic             pop,
  input  logic [CNT_W-1:0] top_thr,
  input  logic [CNT_W-1:0] bott_thr,
  output logic             top_lim,
  output logic             bott_lim,
  output logic             err,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(CNT_MAX);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] bott_q, bott_d;
  lim_flags_t       flags_q, flags_d;

  logic             cnt_en;
  logic [CNT_W-1:0] count_next;
  logic             ovf;
  logic             unf;

  // Counting only happens in the operating states; INIT and ERROR keep the count still.
  assign cnt_en = (state_q == ST_BOTTOM) || (state_q == ST_MID) || (state_q == ST_TOP);

  lim_counter #(
    .CNT_W   (CNT_W),
    .CNT_MAX (CNT_MAX)
  ) u_counter (
    .clk        (clk),
    .reset_L    (reset_L),
    .en         (cnt_en),
    .push       (push),
    .pop        (pop),
    .count_q    (count),
    .count_next (count_next),
    .ovf        (ovf),
    .unf        (unf)
  );

  // Next state and threshold capture; region is chosen from the count being written this edge.
  always_comb begin
    state_d = state_q;
    top_d   = top_q;
    bott_d  = bott_q;
    case (state_q)
      ST_INIT: begin
        top_d  = top_thr;
        bott_d = bott_thr;
        if ((bott_thr >= top_thr) || (top_thr > MAX_V)) begin
          state_d = ST_ERROR;
        end else begin
          state_d = ST_BOTTOM;
        end
      end
      ST_BOTTOM, ST_MID, ST_TOP: begin
        if (ovf || unf) begin
          state_d = ST_ERROR;
        end else if (count_next <= bott_q) begin
          state_d = ST_BOTTOM;
        end else if (count_next >= top_q) begin
          state_d = ST_TOP;
        end else begin
          state_d = ST_MID;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
    flags_d = flags_for(state_d);
  end

  // State, thresholds and output flags all move on the same edge as the count.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_INIT;
      top_q   <= '0;
      bott_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      top_q   <= top_d;
      bott_q  <= bott_d;
      flags_q <= flags_d;
    end
  end

  assign top_lim  = flags_q.top;
  assign bott_lim = flags_q.bott;
  assign err      = flags_q.err;

endmodule

// File: tb/tb_limit_fsm_cond.sv
// tb/tb_limit_fsm_cond.sv - self-checking bench for limit_fsm_cond
module tb_limit_fsm_cond;

  logic       clk;
  logic       reset_L;
  logic       push;
  logic       pop;
  logic [3:0] top_thr;
  logic [3:0] bott_thr;
  logic       top_lim;
  logic       bott_lim;
  logic       err;
  logic [3:0] count;

  int n_checks;
  int n_fail;

  limit_fsm_cond #(.CNT_W(4), .CNT_MAX(15)) dut (
    .clk      (clk),
    .reset_L  (reset_L),
    .push     (push),
    .pop      (pop),
    .top_thr  (top_thr),
    .bott_thr (bott_thr),
    .top_lim  (top_lim),
    .bott_lim (bott_lim),
    .err      (err),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: phase 0 = waiting for first edge, 1 = counting, 2 = failed
  int m_phase;
  int m_cnt;
  int m_top;
  int m_bott;

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      m_phase = 0;
      m_cnt   = 0;
      m_top   = 0;
      m_bott  = 0;
    end else if (m_phase == 0) begin
      m_top   = int'(top_thr);
      m_bott  = int'(bott_thr);
      m_phase = (m_bott >= m_top || m_top > 15) ? 2 : 1;
    end else if (m_phase == 1) begin
      if (push && !pop) begin
        if (m_cnt == 15) m_phase = 2;
        else m_cnt = m_cnt + 1;
      end else if (pop && !push) begin
        if (m_cnt == 0) m_phase = 2;
        else m_cnt = m_cnt - 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // continuous compare against the model on every falling edge
  always @(negedge clk) begin
    int e_bott, e_top;
    e_bott = (m_phase == 1 && m_cnt <= m_bott) ? 1 : 0;
    e_top  = (m_phase == 1 && m_cnt >= m_top && e_bott == 0) ? 1 : 0;
    chk("model_count", int'(count), m_cnt);
    chk("model_bott_lim", int'(bott_lim), e_bott);
    chk("model_top_lim", int'(top_lim), e_top);
    chk("model_err", int'(err), (m_phase == 2) ? 1 : 0);
    chk("lim_exclusive", int'(top_lim & bott_lim), 0);
  end

  task automatic step(input logic p, input logic q);
    push = p;
    pop  = q;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic restart(input logic [3:0] t, input logic [3:0] b);
    reset_L  = 1'b0;
    top_thr  = t;
    bott_thr = b;
    @(posedge clk);
    #1;
    reset_L = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    push     = 1'b0;
    pop      = 1'b0;
    reset_L  = 1'b0;
    top_thr  = 4'd12;
    bott_thr = 4'd3;
    #2;
    chk("rst_count", int'(count), 0);
    chk("rst_flags", int'({top_lim, bott_lim, err}), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_L = 1'b1;
    // cycle 1: still INIT
    chk("init_flags", int'({top_lim, bott_lim, err}), 0);
    step(1'b1, 1'b0); // push ignored in INIT
    chk("bottom_after_init", int'(bott_lim), 1);
    chk("init_count", int'(count), 0);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    chk("count3_bott", int'(bott_lim), 1);
    step(1'b1, 1'b0);
    chk("count4", int'(count), 4);
    chk("count4_bott_fall", int'(bott_lim), 0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
    chk("count11_top", int'(top_lim), 0);
    step(1'b1, 1'b0);
    chk("count12", int'(count), 12);
    chk("count12_top_rise", int'(top_lim), 1);

    step(1'b1, 1'b1);
    chk("pushpop_count", int'(count), 12);
    chk("pushpop_top", int'(top_lim), 1);
    step(1'b0, 1'b1);
    chk("pop_count11", int'(count), 11);
    chk("pop_top_fall", int'(top_lim), 0);

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    chk("count15", int'(count), 15);
    step(1'b1, 1'b0);
    chk("ovf_err", int'(err), 1);
    chk("ovf_top", int'(top_lim), 0);
    chk("ovf_count", int'(count), 15);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("sticky_err", int'(err), 1);
    chk("sticky_count", int'(count), 15);

    // equal thresholds are illegal
    restart(4'd5, 4'd5);
    step(1'b0, 1'b0);
    chk("eq_thr_err", int'(err), 1);

    // underflow from empty
    restart(4'd12, 4'd3);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("unf_err", int'(err), 1);
    chk("unf_count", int'(count), 0);

    // asynchronous reset mid-count
    restart(4'd12, 4'd3);
    step(1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
    chk("mid_count7", int'(count), 7);
    #1;
    reset_L = 1'b0;
    #1;
    chk("async_count", int'(count), 0);
    chk("async_flags", int'({top_lim, bott_lim, err}), 0);
    @(posedge clk);
    #1;

    // re-sampled thresholds after reset, bottom threshold of zero
    top_thr  = 4'd2;
    bott_thr = 4'd0;
    reset_L  = 1'b1;
    step(1'b1, 1'b0);
    chk("resample_bott", int'(bott_lim), 1);
    step(1'b1, 1'b0);
    chk("bott0_mid", int'({top_lim, bott_lim}), 0);
    step(1'b1, 1'b0);
    chk("thr2_top", int'(top_lim), 1);
    chk("thr2_count", int'(count), 2);
    step(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
